mfp_ahb_avalon_bridge: RTL and testbench

AHB-Lite slave to Avalon-MM master bridge for the board's LPDDR2 memory path. It sits between the AHB-Lite matrix inside `mfp_system` and the `lpddr2_mm` controller and drives its `avm_*` port group. Each AHB transfer becomes one single-beat Avalon command, with HREADYOUT stalling the AHB master until the command completes.

---
 rtl/mfp_ahb_avalon_bridge_pkg.sv | 22 ++
 rtl/mfp_ahb_avalon_byteenable.sv | 19 +
 rtl/mfp_ahb_avalon_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_mfp_ahb_avalon_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_ahb_avalon_bridge_pkg.sv
// Shared definitions for the AHB-Lite to Avalon-MM bridge: FSM state
// encodings, AHB transfer/size constants and the fixed Avalon burst length.
package mfp_ahb_avalon_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ_CMD  = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  // Only bit 1 of HTRANS matters: NONSEQ/SEQ start a transfer, IDLE/BUSY do not.
  localparam int unsigned HTRANS_ACTIVE_BIT = 1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;

  // Every AHB transfer maps to exactly one single-beat Avalon command.
  localparam logic [2:0] AVM_BURSTCOUNT = 3'd1;

endpackage

// File: rtl/mfp_ahb_avalon_byteenable.sv
// Maps an AHB transfer size and the low address bits to Avalon byte lanes.
module mfp_ahb_avalon_byteenable
  import mfp_ahb_avalon_bridge_pkg::*;
(
  input  logic [2:0] i_hsize,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_byteenable
);

  // Byte selects one lane, halfword selects a lane pair, anything wider is a full word.
  always_comb begin
    case (i_hsize)
      HSIZE_BYTE: o_byteenable = 4'b0001 << i_addr_lo;
      HSIZE_HALF: o_byteenable = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    o_byteenable = 4'b1111;
    endcase
  end

endmodule

// File: rtl/mfp_ahb_avalon_bridge.sv
// AHB-Lite slave to Avalon-MM master bridge for the LPDDR2 memory path.
// Each AHB transfer becomes one single-beat Avalon command; HREADYOUT stalls
// the AHB master until the command completes.
// Optional build macro MFP_AHB_AVALON_POSTED_WRITE_EN: writes are posted
// through a one-entry buffer; a transfer arriving while the buffer is busy is
// held and launched once the buffered write has been accepted.
module mfp_ahb_avalon_bridge
  import mfp_ahb_avalon_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 27
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  input  logic                  avm_waitrequest,
  input  logic                  avm_readdatavalid,
  input  logic [31:0]           avm_readdata,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic [3:0]            avm_byteenable,
  output logic [2:0]            avm_burstcount,
  output logic [31:0]           avm_writedata,
  output logic                  avm_begintransfer,
  output logic                  avm_beginbursttransfer
);

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_accept;
  logic [3:0]            w_be;
  logic                  w_launch;
  logic                  w_launch_write;
  logic [ADDR_WIDTH-1:2] w_launch_addr;
  logic [3:0]            w_launch_be;
  logic                  w_rd_capture;
  logic [ADDR_WIDTH-1:2] r_addr;
  logic [3:0]            r_be;
  logic [31:0]           r_wdata;
  logic [31:0]           r_hrdata;
  logic                  r_avm_read;
  logic                  r_avm_write;
  logic                  r_begin;
  logic                  w_first_write_cycle;
  logic                  w_unused;

  assign w_accept = HSEL & HREADY & HTRANS[HTRANS_ACTIVE_BIT];

  // HTRANS[0] and the address bits above the Avalon window carry no information here.
  assign w_unused = ^{HTRANS[0], HADDR};

  mfp_ahb_avalon_byteenable u_byteenable (
    .i_hsize      (HSIZE),
    .i_addr_lo    (HADDR[1:0]),
    .o_byteenable (w_be)
  );

`ifdef MFP_AHB_AVALON_POSTED_WRITE_EN
  logic                  r_pend_valid;
  logic                  r_pend_write;
  logic [ADDR_WIDTH-1:2] r_pend_addr;
  logic [3:0]            r_pend_be;
  logic                  w_hold;

  // A held transfer always launches ahead of anything newer on the bus.
  assign w_launch_write = r_pend_valid ? r_pend_write : HWRITE;
  assign w_launch_addr  = r_pend_valid ? r_pend_addr  : HADDR[ADDR_WIDTH-1:2];
  assign w_launch_be    = r_pend_valid ? r_pend_be    : w_be;

  // The buffered write's data phase is already over; only a held transfer stalls the bus.
  assign HREADYOUT = (r_state == ST_IDLE) || (r_state == ST_RESP) ||
                     ((r_state == ST_WRITE) && !r_pend_valid);

  // Capture a transfer that arrives while the write buffer is still draining.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend_valid <= 1'b0;
      r_pend_write <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_be    <= '0;
    end else if (w_hold) begin
      r_pend_valid <= 1'b1;
      r_pend_write <= HWRITE;
      r_pend_addr  <= HADDR[ADDR_WIDTH-1:2];
      r_pend_be    <= w_be;
    end else if (w_launch) begin
      r_pend_valid <= 1'b0;
    end
  end
`else
  assign w_launch_write = HWRITE;
  assign w_launch_addr  = HADDR[ADDR_WIDTH-1:2];
  assign w_launch_be    = w_be;

  assign HREADYOUT = (r_state == ST_IDLE) || (r_state == ST_RESP);
`endif

  // Next-state decode: launch commands, track Avalon handshakes, capture read data.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_launch     = 1'b0;
    w_rd_capture = 1'b0;
`ifdef MFP_AHB_AVALON_POSTED_WRITE_EN
    w_hold       = 1'b0;
`endif
    case (r_state)
      ST_IDLE, ST_RESP: begin
        w_next_state = ST_IDLE;
        if (w_accept) begin
          w_launch     = 1'b1;
          w_next_state = w_launch_write ? ST_WRITE : ST_READ_CMD;
        end
      end
      ST_WRITE: begin
`ifdef MFP_AHB_AVALON_POSTED_WRITE_EN
        if (!avm_waitrequest) begin
          if (r_pend_valid || w_accept) begin
            w_launch     = 1'b1;
            w_next_state = w_launch_write ? ST_WRITE : ST_READ_CMD;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_hold = w_accept;
        end
`else
        if (!avm_waitrequest) begin
          w_next_state = ST_RESP;
        end
`endif
      end
      ST_READ_CMD: begin
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            w_rd_capture = 1'b1;
            w_next_state = ST_RESP;
          end else begin
            w_next_state = ST_READ_WAIT;
          end
        end
      end
      ST_READ_WAIT: begin
        if (avm_readdatavalid) begin
          w_rd_capture = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register plus registered command strobes and first-cycle pulse.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_avm_read  <= 1'b0;
      r_avm_write <= 1'b0;
      r_begin     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_avm_read  <= (w_next_state == ST_READ_CMD);
      r_avm_write <= (w_next_state == ST_WRITE);
      r_begin     <= w_launch;
    end
  end

  // Command attributes are latched when a command launches and held until the next one.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr <= '0;
      r_be   <= '0;
    end else if (w_launch) begin
      r_addr <= w_launch_addr;
      r_be   <= w_launch_be;
    end
  end

  // HWDATA is only guaranteed in the first WRITE cycle, so it is passed through
  // then and held from a register for any waitrequest-extended cycles.
  assign w_first_write_cycle = r_begin & r_avm_write;

  // Hold write data past the AHB data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wdata <= '0;
    end else if (w_first_write_cycle) begin
      r_wdata <= HWDATA;
    end
  end

  // Read data register; keeps its value until the next read captures new data.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hrdata <= '0;
    end else if (w_rd_capture) begin
      r_hrdata <= avm_readdata;
    end
  end

  assign HRDATA                 = r_hrdata;
  assign HRESP                  = 1'b0;
  assign avm_read               = r_avm_read;
  assign avm_write              = r_avm_write;
  assign avm_address            = {r_addr, 2'b00};
  assign avm_byteenable         = r_be;
  assign avm_burstcount         = AVM_BURSTCOUNT;
  assign avm_writedata          = w_first_write_cycle ? HWDATA : r_wdata;
  assign avm_begintransfer      = r_begin;
  assign avm_beginbursttransfer = r_begin;

endmodule

// File: tb/tb_mfp_ahb_avalon_bridge.sv
// Scoreboard bench for mfp_ahb_avalon_bridge: stimulus pushes AHB transfers,
// Avalon slave responses and expected results into queues; a monitor checks
// every Avalon command and every completed AHB data phase.
module tb_mfp_ahb_avalon_bridge;

  localparam int AW = 27;
  localparam logic [31:0] AMASK = 32'h07FF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel, hwrite, hready;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hreadyout, hresp;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        avm_read, avm_write;
  logic [AW-1:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic [2:0]  avm_burstcount;
  logic [31:0] avm_writedata;
  logic        avm_begintransfer, avm_beginbursttransfer;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  mfp_ahb_avalon_bridge #(.ADDR_WIDTH(AW)) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HREADY(hready), .HWDATA(hwdata),
    .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata), .avm_read(avm_read), .avm_write(avm_write),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_writedata(avm_writedata),
    .avm_begintransfer(avm_begintransfer),
    .avm_beginbursttransfer(avm_beginbursttransfer)
  );

  typedef struct { logic write; logic [31:0] addr; logic [2:0] size; logic [31:0] wdata; } ahb_xfer_t;
  typedef struct { int wait_cycles; int lat; logic [31:0] rdata; } slv_cfg_t;
  typedef struct { logic write; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int len; int lat; } exp_cmd_t;
  typedef struct { logic write; int len; logic [31:0] rdata; } exp_dp_t;

  ahb_xfer_t mst_q[$];
  slv_cfg_t  slv_q[$];
  exp_cmd_t  exp_cmd_q[$];
  exp_dp_t   exp_dp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_dp_active  = 1'b0;
  bit mon_cmd_active = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event, expected none (t=%0t)", name, $time);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hreadyout"}, hreadyout, 1'b1);
    check({tag, "_hresp"}, hresp, 1'b0);
    check({tag, "_hrdata"}, hrdata, 32'h0);
    check({tag, "_avm_read"}, avm_read, 1'b0);
    check({tag, "_avm_write"}, avm_write, 1'b0);
    check({tag, "_begintransfer"}, avm_begintransfer, 1'b0);
    check({tag, "_beginburst"}, avm_beginbursttransfer, 1'b0);
    check({tag, "_address"}, avm_address, '0);
    check({tag, "_byteenable"}, avm_byteenable, 4'h0);
    check({tag, "_writedata"}, avm_writedata, 32'h0);
    check({tag, "_burstcount"}, avm_burstcount, 3'd1);
  endtask

  // One transfer: AHB stimulus, Avalon slave behaviour and expected results.
  // dp_len = 0 means the data phase is not expected to complete.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [3:0] be, input int wait_c,
                       input int lat, input logic [31:0] rdata, input int dp_len, input int cmd_lat);
    ahb_xfer_t x;
    slv_cfg_t  s;
    exp_cmd_t  c;
    exp_dp_t   d;
    x = '{write: wr, addr: addr, size: size, wdata: wdata};
    s = '{wait_cycles: wait_c, lat: lat, rdata: rdata};
    c = '{write: wr, addr: addr & AMASK, be: be, wdata: wdata, len: wait_c + 1, lat: cmd_lat};
    d = '{write: wr, len: dp_len, rdata: rdata};
    slv_q.push_back(s);
    exp_cmd_q.push_back(c);
    if (dp_len > 0) exp_dp_q.push_back(d);
    mst_q.push_back(x);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (mst_q.size() == 0 && exp_cmd_q.size() == 0 && exp_dp_q.size() == 0 &&
          !mon_cmd_active && !mon_dp_active) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) report_fail({name, "_drain_timeout"});
    repeat (2) @(posedge clk);
  endtask

  // AHB master: advances its pipeline only on edges where HREADY was high.
  initial begin : ahb_master
    ahb_xfer_t cur;
    bit        ap_valid;
    logic      ap_write;
    logic [31:0] ap_wdata;
    bit        hr;
    ap_valid = 1'b0; ap_write = 1'b0; ap_wdata = '0;
    hsel = 1'b0; htrans = 2'b00; haddr = '0; hsize = '0; hwrite = 1'b0; hwdata = '0;
    forever begin
      @(negedge clk);
      hr = hreadyout;
      @(posedge clk);
      #1;
      if (hr) begin
        if (ap_valid && ap_write) hwdata = ap_wdata;
        if (mst_q.size() > 0) begin
          cur = mst_q.pop_front();
          hsel = 1'b1; htrans = 2'b10; haddr = cur.addr; hsize = cur.size; hwrite = cur.write;
          ap_valid = 1'b1; ap_write = cur.write; ap_wdata = cur.wdata;
        end else begin
          hsel = 1'b0; htrans = 2'b00;
          ap_valid = 1'b0;
        end
      end
    end
  end

  // Avalon slave: programmable waitrequest count and readdatavalid latency.
  initial begin : avalon_slave
    slv_cfg_t cfg;
    bit  busy, rd_pend;
    int  wait_left, rd_cnt;
    logic [31:0] rd_data;
    busy = 1'b0; rd_pend = 1'b0; wait_left = 0; rd_cnt = 0; rd_data = '0;
    cfg = '{wait_cycles: 0, lat: 0, rdata: 32'h0};
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    forever begin
      @(posedge clk);
      #1;
      avm_readdatavalid = 1'b0;
      if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = rd_data;
          rd_pend = 1'b0;
        end
      end
      if ((avm_read || avm_write) && rst_n) begin
        if (!busy) begin
          if (slv_q.size() > 0) cfg = slv_q.pop_front();
          else begin
            report_fail("slave_unplanned_cmd");
            cfg = '{wait_cycles: 0, lat: 0, rdata: 32'h0};
          end
          busy = 1'b1;
          wait_left = cfg.wait_cycles;
        end
        if (wait_left > 0) begin
          avm_waitrequest = 1'b1;
          wait_left--;
        end else begin
          avm_waitrequest = 1'b0;
          busy = 1'b0;
          if (avm_read) begin
            if (cfg.lat == 0) begin
              avm_readdatavalid = 1'b1;
              avm_readdata = cfg.rdata;
            end else begin
              rd_pend = 1'b1;
              rd_cnt = cfg.lat;
              rd_data = cfg.rdata;
            end
          end
        end
      end else begin
        avm_waitrequest = 1'b0;
        busy = 1'b0;
      end
    end
  end

  // Monitor: compares Avalon commands and completed AHB data phases to the scoreboard.
  initial begin : monitor
    int cyc, dp_len, cmd_len;
    int acc_q[$];
    exp_cmd_t c;
    exp_dp_t  d;
    cyc = 0; dp_len = 0; cmd_len = 0;
    c = '{write: 1'b0, addr: '0, be: '0, wdata: '0, len: 0, lat: 0};
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mon_dp_active = 1'b0;
        mon_cmd_active = 1'b0;
        acc_q.delete();
      end else begin
        if (avm_read) check("no_rw_overlap", avm_write, 1'b0);
        if (avm_begintransfer || avm_beginbursttransfer)
          check("burst_pulse_match", avm_beginbursttransfer, avm_begintransfer);
        if (avm_begintransfer) begin
          if (exp_cmd_q.size() == 0) report_fail("unexpected_cmd");
          else begin
            c = exp_cmd_q.pop_front();
            check("cmd_write", avm_write, c.write);
            check("cmd_read", avm_read, !c.write);
            check("cmd_addr", avm_address, c.addr[AW-1:0]);
            check("cmd_be", avm_byteenable, c.be);
            check("cmd_burstcount", avm_burstcount, 3'd1);
            if (c.write) check("cmd_wdata", avm_writedata, c.wdata);
            if (acc_q.size() == 0) report_fail("cmd_without_accept");
            else check("cmd_latency", cyc - acc_q.pop_front(), c.lat);
            mon_cmd_active = 1'b1;
            cmd_len = 0;
          end
        end
        if (mon_cmd_active) begin
          cmd_len++;
          if (c.write) check("cmd_wdata_stable", avm_writedata, c.wdata);
          if (!avm_waitrequest) begin
            check("cmd_len", cmd_len, c.len);
            mon_cmd_active = 1'b0;
          end
        end
        if (mon_dp_active) begin
          dp_len++;
          if (hreadyout) begin
            mon_dp_active = 1'b0;
            check("hresp", hresp, 1'b0);
            if (exp_dp_q.size() == 0) report_fail("unexpected_dp");
            else begin
              d = exp_dp_q.pop_front();
              check("dp_len", dp_len, d.len);
              if (!d.write) check("hrdata", hrdata, d.rdata);
            end
          end
        end
        if (hsel && hready && htrans[1]) begin
          acc_q.push_back(cyc);
          mon_dp_active = 1'b1;
          dp_len = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin : stimulus
    bit seen;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst0");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

`ifdef MFP_AHB_AVALON_POSTED_WRITE_EN
    // Posted write with 5 wait cycles, then a read that must wait behind it.
    issue(1'b1, 32'h300, 3'd2, 32'h55AA55AA, 4'b1111, 5, 0, 32'h0,       1, 1);
    issue(1'b0, 32'h304, 3'd2, 32'h0,        4'b1111, 0, 0, 32'h600DF00D, 7, 6);
    drain("posted_wr_rd");
    issue(1'b0, 32'h44,  3'd2, 32'h0,        4'b1111, 0, 0, 32'h5A5A0FF0, 2, 1);
    drain("posted_rd");
`else
    // Word write, 3 waitrequest cycles: avm_write held 4 cycles, data phase 5.
    issue(1'b1, 32'h100, 3'd2, 32'h12345678, 4'b1111, 3, 0, 32'h0,       5, 1);
    drain("wr_word_wait3");
    // Byte read at 0x103, readdatavalid one cycle after command acceptance.
    issue(1'b0, 32'h103, 3'd0, 32'h0,        4'b1000, 0, 1, 32'hAABBCCDD, 3, 1);
    drain("rd_byte_103");
    // Back-to-back halfword write then word read.
    issue(1'b1, 32'h002, 3'd1, 32'hBEEF0000, 4'b1100, 0, 0, 32'h0,       2, 1);
    issue(1'b0, 32'h008, 3'd2, 32'h0,        4'b1111, 0, 0, 32'h11223344, 2, 1);
    drain("b2b_wr_rd");
    // Immediate readdatavalid: READ_CMD straight to RESP.
    issue(1'b0, 32'h044, 3'd2, 32'h0,        4'b1111, 0, 0, 32'h5A5A0FF0, 2, 1);
    drain("rd_immediate");
    // Read with two wait cycles.
    issue(1'b0, 32'h040, 3'd2, 32'h0,        4'b1111, 2, 0, 32'h01020304, 4, 1);
    drain("rd_wait2");
    // Upper halfword read, one wait cycle and three cycles of data latency.
    issue(1'b0, 32'h006, 3'd1, 32'h0,        4'b1100, 1, 3, 32'h0BAD0BAD, 6, 1);
    drain("rd_half_lat3");
    // Byte write at lane 1.
    issue(1'b1, 32'h201, 3'd0, 32'h0000AB00, 4'b0010, 0, 0, 32'h0,       2, 1);
    drain("wr_byte_201");
`endif

    // Reset while waiting for read data; the late readdatavalid must be dropped.
    issue(1'b0, 32'h080, 3'd2, 32'h0, 4'b1111, 0, 6, 32'hDEADBEEF, 0, 1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (exp_cmd_q.size() == 0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) report_fail("rst_mid_cmd_timeout");
    #1;
    check("read_wait_hreadyout", hreadyout, 1'b0);
    check("read_wait_avm_read", avm_read, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst1");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("late_rdv_hrdata", hrdata, 32'h0);
    check("late_rdv_hreadyout", hreadyout, 1'b1);
    mon_dp_active = 1'b0;

    // Normal operation after reset.
    issue(1'b0, 32'h00C, 3'd2, 32'h0, 4'b1111, 0, 0, 32'hCAFEF00D, 2, 1);
    drain("rd_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
